// File: rtl/registerfile_2r1w_param.sv
// -----------------------------------------------------------------------------
// registerfile_2r1w_param
//
// Purpose:
//   Parametrised register file with one write port (C) and two independent
//   registered read ports (A, B).
//   - Optional same-edge write-to-read forwarding (BYPASS).
//   - Optional hard-wired zero register 0 (R0_ZERO).
//   - Built-in sweep engine that zeroes the whole file over DEPTH cycles.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   select width, DEPTH = 2**ADDR_W
//   R0_ZERO  1: register 0 reads as 0 and writes to it are discarded
//   BYPASS   1: a read of the address written at the same edge returns new data
//
// Ports:
//   in_clk       clock, rising edge
//   in_clr       asynchronous active-low reset
//   in_Cdata     write data
//   in_Cselect   write address
//   in_write     write request
//   in_Aselect   read port A address
//   in_Aread     read port A request
//   out_Adata    read port A data (registered)
//   out_Avalid   1-cycle pulse, out_Adata updated
//   in_Bselect   read port B address
//   in_Bread     read port B request
//   out_Bdata    read port B data (registered)
//   out_Bvalid   1-cycle pulse, out_Bdata updated
//   in_sweep     request to zero every register
//   out_busy     high while the sweep runs (exactly DEPTH cycles)
//   out_wr_drop  1-cycle pulse, a write was rejected during the sweep
// -----------------------------------------------------------------------------
module registerfile_2r1w_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter bit R0_ZERO = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              in_clk,
  input  logic              in_clr,
  input  logic [DATA_W-1:0] in_Cdata,
  input  logic [ADDR_W-1:0] in_Cselect,
  input  logic              in_write,
  input  logic [ADDR_W-1:0] in_Aselect,
  input  logic              in_Aread,
  output logic [DATA_W-1:0] out_Adata,
  output logic              out_Avalid,
  input  logic [ADDR_W-1:0] in_Bselect,
  input  logic              in_Bread,
  output logic [DATA_W-1:0] out_Bdata,
  output logic              out_Bvalid,
  input  logic              in_sweep,
  output logic              out_busy,
  output logic              out_wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] adata_q, adata_d;
  logic [DATA_W-1:0] bdata_q, bdata_d;
  logic              avalid_q, bvalid_q, drop_q;
  logic              busy;
  logic              wr_en;

  assign busy = (state_q == ST_SWEEP);

  // Writes to a hard-wired zero register are discarded silently, not dropped.
  assign wr_en = in_write && !busy && !(R0_ZERO && (in_Cselect == '0));

  // Resolve the value each read port captures at this edge. Priority:
  // sweep in progress (file counts as cleared) > zero register > bypass > array.
  function automatic logic [DATA_W-1:0] read_value(
    input logic [ADDR_W-1:0] sel,
    input logic              sweeping,
    input logic              wen,
    input logic [ADDR_W-1:0] wsel,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (sweeping) begin
      v = '0;
    end else if (R0_ZERO && (sel == '0)) begin
      v = '0;
    end else if (BYPASS && wen && (wsel == sel)) begin
      v = wdata;
    end
    return v;
  endfunction

  always_comb begin
    adata_d = adata_q;
    bdata_d = bdata_q;
    if (in_Aread) begin
      adata_d = read_value(in_Aselect, busy, wr_en, in_Cselect, in_Cdata, mem_q[in_Aselect]);
    end
    if (in_Bread) begin
      bdata_d = read_value(in_Bselect, busy, wr_en, in_Cselect, in_Cdata, mem_q[in_Bselect]);
    end
  end

  // Sweep sequencer: counter walks 0..DEPTH-1, one entry cleared per edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_sweep) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage array
  always_ff @(posedge in_clk or negedge in_clr) begin
    if (!in_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[in_Cselect] <= in_Cdata;
    end
  end

  // Control and output registers
  always_ff @(posedge in_clk or negedge in_clr) begin
    if (!in_clr) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      adata_q  <= '0;
      bdata_q  <= '0;
      avalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adata_q  <= adata_d;
      bdata_q  <= bdata_d;
      avalid_q <= in_Aread;
      bvalid_q <= in_Bread;
      drop_q   <= in_write && busy;
    end
  end

  assign out_Adata   = adata_q;
  assign out_Bdata   = bdata_q;
  assign out_Avalid  = avalid_q;
  assign out_Bvalid  = bvalid_q;
  assign out_busy    = busy;
  assign out_wr_drop = drop_q;

endmodule

// File: tb/tb_registerfile_2r1w_param.sv
module tb_registerfile_2r1w_param;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam bit R0_ZERO = 1'b1;
  localparam bit BYPASS  = 1'b1;

  logic              in_clk = 1'b0;
  logic              in_clr = 1'b0;
  logic [DATA_W-1:0] in_Cdata = '0;
  logic [ADDR_W-1:0] in_Cselect = '0;
  logic              in_write = 1'b0;
  logic [ADDR_W-1:0] in_Aselect = '0;
  logic              in_Aread = 1'b0;
  logic [DATA_W-1:0] out_Adata;
  logic              out_Avalid;
  logic [ADDR_W-1:0] in_Bselect = '0;
  logic              in_Bread = 1'b0;
  logic [DATA_W-1:0] out_Bdata;
  logic              out_Bvalid;
  logic              in_sweep = 1'b0;
  logic              out_busy;
  logic              out_wr_drop;

  registerfile_2r1w_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .R0_ZERO(R0_ZERO),
    .BYPASS (BYPASS)
  ) dut (
    .in_clk     (in_clk),
    .in_clr     (in_clr),
    .in_Cdata   (in_Cdata),
    .in_Cselect (in_Cselect),
    .in_write   (in_write),
    .in_Aselect (in_Aselect),
    .in_Aread   (in_Aread),
    .out_Adata  (out_Adata),
    .out_Avalid (out_Avalid),
    .in_Bselect (in_Bselect),
    .in_Bread   (in_Bread),
    .out_Bdata  (out_Bdata),
    .out_Bvalid (out_Bvalid),
    .in_sweep   (in_sweep),
    .out_busy   (out_busy),
    .out_wr_drop(out_wr_drop)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the register file as a plain array plus the number of
  // busy cycles still to come.
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                sweep_left = 0;
  logic [DATA_W-1:0] qa[$];
  logic [DATA_W-1:0] qb[$];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    sweep_left = 0;
    qa.delete();
    qb.delete();
  endtask

  // One clock edge: predict from the current inputs, apply the edge, then
  // check the per-cycle status outputs. Read data goes to the scoreboard.
  task automatic cycle();
    bit                busy_now;
    bit                wen;
    bit                exp_drop;
    logic [DATA_W-1:0] v;
    busy_now = (sweep_left > 0);
    wen = in_write && !busy_now && !(R0_ZERO && in_Cselect == 0);
    if (in_Aread) begin
      if (busy_now || (R0_ZERO && in_Aselect == 0)) v = '0;
      else if (BYPASS && wen && in_Cselect == in_Aselect) v = in_Cdata;
      else v = model_mem[in_Aselect];
      qa.push_back(v);
    end
    if (in_Bread) begin
      if (busy_now || (R0_ZERO && in_Bselect == 0)) v = '0;
      else if (BYPASS && wen && in_Cselect == in_Bselect) v = in_Cdata;
      else v = model_mem[in_Bselect];
      qb.push_back(v);
    end
    exp_drop = in_write && busy_now;
    if (wen) model_mem[in_Cselect] = in_Cdata;
    if (busy_now) begin
      sweep_left--;
    end else if (in_sweep) begin
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end
    @(posedge in_clk);
    #1;
    check("busy", 32'(out_busy), 32'(sweep_left > 0));
    check("wr_drop", 32'(out_wr_drop), 32'(exp_drop));
  endtask

  task automatic idle_inputs();
    in_write = 1'b0;
    in_Aread = 1'b0;
    in_Bread = 1'b0;
    in_sweep = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a read port presents data.
  always @(negedge in_clk) begin
    if (in_clr) begin
      if (out_Avalid) begin
        if (qa.size() == 0) check("A_unexpected_valid", 32'd1, 32'd0);
        else check("A_data", out_Adata, qa.pop_front());
      end
      if (out_Bvalid) begin
        if (qb.size() == 0) check("B_unexpected_valid", 32'd1, 32'd0);
        else check("B_data", out_Bdata, qb.pop_front());
      end
    end
  end

  task automatic fill_all(input logic [DATA_W-1:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      in_write = 1'b1;
      in_Cselect = ADDR_W'(i);
      in_Cdata = base + DATA_W'(i * 32'h01010101);
      cycle();
    end
    idle_inputs();
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      in_write   = ($urandom_range(0, 99) < 60);
      in_Cselect = ADDR_W'($urandom_range(0, DEPTH - 1));
      in_Cdata   = $urandom;
      in_Aread   = ($urandom_range(0, 99) < 70);
      in_Aselect = ($urandom_range(0, 3) == 0) ? in_Cselect : ADDR_W'($urandom_range(0, DEPTH - 1));
      in_Bread   = ($urandom_range(0, 99) < 70);
      in_Bselect = ($urandom_range(0, 3) == 0) ? in_Aselect : ADDR_W'($urandom_range(0, DEPTH - 1));
      in_sweep   = ($urandom_range(0, 99) < 3);
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    int n;
    model_reset();

    // Reset state
    #12;
    check("rst_Adata", out_Adata, '0);
    check("rst_Bdata", out_Bdata, '0);
    check("rst_valids", {30'd0, out_Avalid, out_Bvalid}, '0);
    check("rst_busy_drop", {30'd0, out_busy, out_wr_drop}, '0);
    @(negedge in_clk);
    in_clr = 1'b1;
    @(posedge in_clk);
    #1;

    // Every register reads 0 after reset
    for (int i = 0; i < DEPTH; i++) begin
      in_Aread = 1'b1;
      in_Aselect = ADDR_W'(i);
      cycle();
    end
    idle_inputs();

    // Write then read on both ports
    in_write = 1'b1; in_Cselect = 4'd3; in_Cdata = 32'h11111111;
    cycle();
    idle_inputs();
    in_Aread = 1'b1; in_Aselect = 4'd3; in_Bread = 1'b1; in_Bselect = 4'd3;
    cycle();
    idle_inputs();
    cycle();

    // Same-edge write and read (forwarded)
    in_write = 1'b1; in_Cselect = 4'd5; in_Cdata = 32'hCAFE0001;
    in_Aread = 1'b1; in_Aselect = 4'd5;
    cycle();
    idle_inputs();

    // Register 0 write discarded without a drop pulse
    in_write = 1'b1; in_Cselect = 4'd0; in_Cdata = 32'hFFFFFFFF;
    cycle();
    idle_inputs();
    in_Aread = 1'b1; in_Aselect = 4'd0;
    cycle();
    idle_inputs();
    cycle();

    random_phase(300);
    while (sweep_left > 0) cycle();

    // Full sweep: busy length, dropped write, file cleared afterwards
    fill_all(32'h10203040);
    in_sweep = 1'b1;
    cycle();
    in_sweep = 1'b0;
    n = 0;
    while (out_busy && n < 40) begin
      if (n == 3) begin
        in_write = 1'b1; in_Cselect = 4'd7; in_Cdata = 32'hDEADBEEF;
      end
      if (n == 5) begin
        in_Aread = 1'b1; in_Aselect = 4'd9;
      end
      cycle();
      idle_inputs();
      n++;
    end
    check("busy_cycles", 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      in_Aread = 1'b1; in_Aselect = ADDR_W'(i);
      in_Bread = 1'b1; in_Bselect = ADDR_W'(DEPTH - 1 - i);
      cycle();
    end
    idle_inputs();
    cycle();

    // Reset in the middle of a sweep
    fill_all(32'h55AA0000);
    in_Aread = 1'b1; in_Aselect = 4'd5; in_Bread = 1'b1; in_Bselect = 4'd6;
    cycle();
    idle_inputs();
    cycle();
    in_sweep = 1'b1;
    cycle();
    in_sweep = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    in_clr = 1'b0;
    #1;
    model_reset();
    check("midrst_Adata", out_Adata, '0);
    check("midrst_Bdata", out_Bdata, '0);
    check("midrst_busy", 32'(out_busy), 32'd0);
    check("midrst_valid_drop", {29'd0, out_Avalid, out_Bvalid, out_wr_drop}, '0);
    repeat (2) @(posedge in_clk);
    @(negedge in_clr ? in_clk : in_clk);
    in_clr = 1'b1;
    @(posedge in_clk);
    #1;
    check("post_rst_busy", 32'(out_busy), 32'd0);
    in_Aread = 1'b1; in_Aselect = 4'd9;
    cycle();
    idle_inputs();
    in_write = 1'b1; in_Cselect = 4'd9; in_Cdata = 32'h0BADF00D;
    cycle();
    idle_inputs();
    in_Aread = 1'b1; in_Aselect = 4'd9; in_Bread = 1'b1; in_Bselect = 4'd9;
    cycle();
    idle_inputs();
    random_phase(200);
    idle_inputs();
    repeat (2) cycle();

    check("A_queue_drained", 32'(qa.size()), 32'd0);
    check("B_queue_drained", 32'(qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
